// File: rtl/sinfonia_jogo_param.sv
// sinfonia_jogo_param
// Game core for the note-sequence memory game. Each round r shows notes 0..r
// read from an external note memory, then waits for the player to repeat
// them on the buttons. Tracks score, error budget, timeout and training mode.
// Ports:
//   clock, reset (synchronous, active-low)
//   jogar        start level (rising edge), treinamento / nivel latched on it
//   botoes       synchronised button levels
//   mem_addr     note memory address; mem_dado is the note index read back
//   leds         one-hot note shown / button echo
//   arduino_out  synth note code: 0 = silence, k+1 = note k
//   pontos       score; rodada current round
//   pronto/acertou/errou end-of-game flags; db_estado FSM state
module sinfonia_jogo_param #(
  parameter int N_NOTAS     = 7,
  parameter int DEPTH       = 16,
  parameter int NOTE_CICLOS = 1000,
  parameter int GAP_CICLOS  = 500,
  parameter int TIMEOUT_CIC = 5000,
  parameter int PONTOS_INI  = 100,
  parameter int PENALTY     = 10,
  parameter int BONUS       = 5,
  parameter int MAX_ERROS   = 3,
  parameter int PW          = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int NW = $clog2(N_NOTAS),
  localparam int CW = $clog2(N_NOTAS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               jogar,
  input  logic               treinamento,
  input  logic               nivel,
  input  logic [N_NOTAS-1:0] botoes,
  output logic [AW-1:0]      mem_addr,
  input  logic [NW-1:0]      mem_dado,
  output logic [N_NOTAS-1:0] leds,
  output logic [CW-1:0]      arduino_out,
  output logic [PW-1:0]      pontos,
  output logic [AW-1:0]      rodada,
  output logic               pronto,
  output logic               acertou,
  output logic               errou,
  output logic [4:0]         db_estado
);

  // The timer is shared by SHOW, GAP and WAIT, so size it for the longest.
  localparam int TMAX0 = (NOTE_CICLOS > GAP_CICLOS) ? NOTE_CICLOS : GAP_CICLOS;
  localparam int TMAX  = (TMAX0 > TIMEOUT_CIC) ? TMAX0 : TIMEOUT_CIC;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int EW    = $clog2(MAX_ERROS + 1);

  localparam logic [TW-1:0]      NOTE_LAST = TW'(NOTE_CICLOS - 1);
  localparam logic [TW-1:0]      GAP_LAST  = TW'(GAP_CICLOS - 1);
  localparam logic [TW-1:0]      TO_LAST   = TW'(TIMEOUT_CIC - 1);
  localparam logic [EW-1:0]      ERR_LAST  = EW'(MAX_ERROS - 1);
  localparam logic [AW-1:0]      LIM_FULL  = AW'(DEPTH - 1);
  localparam logic [AW-1:0]      LIM_HALF  = AW'(DEPTH / 2 - 1);
  localparam logic [PW-1:0]      PONTOS_W  = PW'(PONTOS_INI);
  localparam logic [PW:0]        BONUS_W   = (PW + 1)'(BONUS);
  localparam logic [PW:0]        PEN_W     = (PW + 1)'(PENALTY);
  localparam logic [N_NOTAS-1:0] ONE_N     = N_NOTAS'(1);

  typedef enum logic [4:0] {
    S_IDLE  = 5'd0,
    S_PREP  = 5'd1,
    S_SHOW  = 5'd2,
    S_GAP   = 5'd3,
    S_WAIT  = 5'd4,
    S_CHECK = 5'd5,
    S_NEXTN = 5'd6,
    S_NEXTR = 5'd7,
    S_ERR   = 5'd8,
    S_WIN   = 5'd9,
    S_LOSE  = 5'd10
  } state_t;

  state_t             state_reg;
  logic [AW-1:0]      addr_reg;
  logic [AW-1:0]      rodada_reg;
  logic [TW-1:0]      timer_reg;
  logic [EW-1:0]      erros_reg;
  logic [PW-1:0]      pontos_reg;
  logic [N_NOTAS-1:0] press_reg;
  logic [N_NOTAS-1:0] botoes_prev_reg;
  logic               jogar_prev_reg;
  logic               treino_reg;
  logic               nivel_reg;
  logic               pronto_reg;
  logic               acertou_reg;
  logic               errou_reg;

  logic               start_edge;
  logic               press;
  logic [N_NOTAS-1:0] nota_onehot;
  logic [AW-1:0]      lim;
  logic [PW:0]        soma_bonus;
  logic [PW-1:0]      pontos_mais;
  logic [PW-1:0]      pontos_menos;
  logic [CW-1:0]      codigo_botao;

  assign start_edge  = jogar & ~jogar_prev_reg;
  // A press only counts on a transition from all-released, so buttons still
  // held when WAIT is entered are ignored until they are let go.
  assign press       = (botoes != '0) && (botoes_prev_reg == '0);
  assign nota_onehot = ONE_N << mem_dado;
  assign lim         = nivel_reg ? LIM_FULL : LIM_HALF;

  // Saturating score arithmetic: add clips at all-ones, subtract clips at 0.
  assign soma_bonus   = {1'b0, pontos_reg} + BONUS_W;
  assign pontos_mais  = soma_bonus[PW] ? '1 : soma_bonus[PW-1:0];
  assign pontos_menos = ({1'b0, pontos_reg} < PEN_W) ? '0
                      : pontos_reg - PEN_W[PW-1:0];

  // Button echo to the synth is only meaningful for a single button.
  always_comb begin
    codigo_botao = '0;
    for (int i = 0; i < N_NOTAS; i++) begin
      if (botoes[i]) codigo_botao = CW'(i + 1);
    end
    if (!$onehot(botoes)) codigo_botao = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      addr_reg        <= '0;
      rodada_reg      <= '0;
      timer_reg       <= '0;
      erros_reg       <= '0;
      pontos_reg      <= '0;
      press_reg       <= '0;
      botoes_prev_reg <= '0;
      jogar_prev_reg  <= 1'b0;
      treino_reg      <= 1'b0;
      nivel_reg       <= 1'b0;
      pronto_reg      <= 1'b0;
      acertou_reg     <= 1'b0;
      errou_reg       <= 1'b0;
    end else begin
      jogar_prev_reg  <= jogar;
      botoes_prev_reg <= botoes;
      case (state_reg)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start_edge) begin
            state_reg   <= S_PREP;
            pronto_reg  <= 1'b0;
            acertou_reg <= 1'b0;
            errou_reg   <= 1'b0;
            pontos_reg  <= PONTOS_W;
            erros_reg   <= '0;
            rodada_reg  <= '0;
            treino_reg  <= treinamento;
            nivel_reg   <= nivel;
          end
        end
        S_PREP: begin
          addr_reg  <= '0;
          timer_reg <= '0;
          state_reg <= S_SHOW;
        end
        S_SHOW: begin
          if (timer_reg == NOTE_LAST) begin
            timer_reg <= '0;
            state_reg <= S_GAP;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        S_GAP: begin
          if (timer_reg == GAP_LAST) begin
            timer_reg <= '0;
            if (addr_reg < rodada_reg) begin
              addr_reg  <= addr_reg + AW'(1);
              state_reg <= S_SHOW;
            end else begin
              addr_reg  <= '0;
              state_reg <= S_WAIT;
            end
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        S_WAIT: begin
          // Press is tested first so it wins over a simultaneous timeout.
          if (press) begin
            press_reg <= botoes;
            state_reg <= S_CHECK;
          end else if (timer_reg == TO_LAST) begin
            state_reg <= S_ERR;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        S_CHECK: begin
          // Exact match with the one-hot note also rejects multi-bit presses.
          if (press_reg == nota_onehot) begin
            if (addr_reg < rodada_reg) begin
              addr_reg  <= addr_reg + AW'(1);
              timer_reg <= '0;
              state_reg <= S_NEXTN;
            end else begin
              state_reg <= S_NEXTR;
            end
          end else begin
            state_reg <= S_ERR;
          end
        end
        S_NEXTN: begin
          timer_reg <= '0;
          if (botoes == '0) state_reg <= S_WAIT;
        end
        S_NEXTR: begin
          pontos_reg <= pontos_mais;
          if (rodada_reg == lim) begin
            pronto_reg  <= 1'b1;
            acertou_reg <= 1'b1;
            state_reg   <= S_WIN;
          end else begin
            rodada_reg <= rodada_reg + AW'(1);
            state_reg  <= S_PREP;
          end
        end
        S_ERR: begin
          if (treino_reg) begin
            state_reg <= S_PREP;
          end else begin
            pontos_reg <= pontos_menos;
            erros_reg  <= erros_reg + EW'(1);
            if (erros_reg == ERR_LAST) begin
              pronto_reg <= 1'b1;
              errou_reg  <= 1'b1;
              state_reg  <= S_LOSE;
            end else begin
              state_reg <= S_PREP;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // LED / synth drive is a pure function of the current state.
  always_comb begin
    leds        = '0;
    arduino_out = '0;
    case (state_reg)
      S_SHOW: begin
        leds        = nota_onehot;
        arduino_out = CW'(mem_dado) + CW'(1);
      end
      S_WAIT: begin
        leds        = botoes;
        arduino_out = codigo_botao;
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_reg;
  assign pontos    = pontos_reg;
  assign rodada    = rodada_reg;
  assign pronto    = pronto_reg;
  assign acertou   = acertou_reg;
  assign errou     = errou_reg;
  assign db_estado = state_reg;

endmodule

// File: tb/tb_sinfonia_jogo_param.sv
// tb_sinfonia_jogo_param
// Directed bench for sinfonia_jogo_param with a small 4-deep note memory.
// A second instance with a low initial score shares all stimulus and shows
// saturation of the score at zero.
module tb_sinfonia_jogo_param;

  localparam logic [4:0] S_IDLE  = 5'd0;
  localparam logic [4:0] S_PREP  = 5'd1;
  localparam logic [4:0] S_SHOW  = 5'd2;
  localparam logic [4:0] S_GAP   = 5'd3;
  localparam logic [4:0] S_WAIT  = 5'd4;
  localparam logic [4:0] S_CHECK = 5'd5;
  localparam logic [4:0] S_NEXTN = 5'd6;
  localparam logic [4:0] S_NEXTR = 5'd7;
  localparam logic [4:0] S_ERR   = 5'd8;
  localparam logic [4:0] S_WIN   = 5'd9;
  localparam logic [4:0] S_LOSE  = 5'd10;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic       treinamento;
  logic       nivel;
  logic [6:0] botoes;

  logic [1:0] mem_addr,   mem_addr2;
  logic [2:0] mem_dado,   mem_dado2;
  logic [6:0] leds,       leds2;
  logic [2:0] arduino_out, arduino_out2;
  logic [7:0] pontos,     pontos2;
  logic [1:0] rodada,     rodada2;
  logic       pronto, acertou, errou;
  logic       pronto2, acertou2, errou2;
  logic [4:0] db_estado,  db_estado2;

  logic [2:0] mem [0:3];
  assign mem_dado  = mem[mem_addr];
  assign mem_dado2 = mem[mem_addr2];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sinfonia_jogo_param #(
    .N_NOTAS(7), .DEPTH(4), .NOTE_CICLOS(4), .GAP_CICLOS(2), .TIMEOUT_CIC(20),
    .PONTOS_INI(100), .PENALTY(10), .BONUS(5), .MAX_ERROS(3), .PW(8)
  ) u_dut (
    .clock(clock), .reset(reset), .jogar(jogar), .treinamento(treinamento),
    .nivel(nivel), .botoes(botoes), .mem_addr(mem_addr), .mem_dado(mem_dado),
    .leds(leds), .arduino_out(arduino_out), .pontos(pontos), .rodada(rodada),
    .pronto(pronto), .acertou(acertou), .errou(errou), .db_estado(db_estado)
  );

  sinfonia_jogo_param #(
    .N_NOTAS(7), .DEPTH(4), .NOTE_CICLOS(4), .GAP_CICLOS(2), .TIMEOUT_CIC(20),
    .PONTOS_INI(15), .PENALTY(10), .BONUS(5), .MAX_ERROS(3), .PW(8)
  ) u_dut_sat (
    .clock(clock), .reset(reset), .jogar(jogar), .treinamento(treinamento),
    .nivel(nivel), .botoes(botoes), .mem_addr(mem_addr2), .mem_dado(mem_dado2),
    .leds(leds2), .arduino_out(arduino_out2), .pontos(pontos2), .rodada(rodada2),
    .pronto(pronto2), .acertou(acertou2), .errou(errou2), .db_estado(db_estado2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [4:0] st, input int budget);
    int n = 0;
    while (db_estado !== st && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(db_estado), 32'(st));
  endtask

  task automatic start_game(input logic t, input logic n);
    jogar = 1'b0;
    treinamento = t;
    nivel = n;
    tick();
    jogar = 1'b1;
    tick();
    jogar = 1'b0;
    check("start_prep", 32'(db_estado), 32'(S_PREP));
  endtask

  task automatic press(input logic [6:0] b, input string tag);
    wait_state({tag, "_wait"}, S_WAIT, 400);
    botoes = b;
    tick();
    botoes = '0;
    tick();
    $display("press %s botoes=%b state=%0d pontos=%0d", tag, b, db_estado, pontos);
  endtask

  task automatic play_round(input int r);
    logic [6:0] b;
    for (int i = 0; i <= r; i++) begin
      b = 7'(1) << mem[i];
      press(b, "ok");
      check("round_step", 32'(db_estado), (i < r) ? 32'(S_NEXTN) : 32'(S_NEXTR));
    end
  endtask

  initial begin
    mem[0] = 3'd3; mem[1] = 3'd0; mem[2] = 3'd6; mem[3] = 3'd1;
    reset = 1'b0; jogar = 1'b0; treinamento = 1'b0; nivel = 1'b0; botoes = '0;
    tick(); tick();
    check("rst_state", 32'(db_estado), 32'(S_IDLE));
    check("rst_pontos", 32'(pontos), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    reset = 1'b1;
    tick();

    // 1: full level, all correct
    start_game(1'b0, 1'b1);
    check("start_pontos", 32'(pontos), 32'd100);
    check("start_pontos_sat", 32'(pontos2), 32'd15);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("show_state", 32'(db_estado), 32'(S_SHOW));
      check("show_leds", 32'(leds), 32'b0001000);
      check("show_ard", 32'(arduino_out), 32'd4);
      tick();
    end
    check("gap_state", 32'(db_estado), 32'(S_GAP));
    check("gap_leds", 32'(leds), 32'd0);
    check("gap_ard", 32'(arduino_out), 32'd0);
    for (int r = 0; r < 4; r++) begin
      play_round(r);
      tick();
      if (r < 3) begin
        check("nextr_prep", 32'(db_estado), 32'(S_PREP));
        check("nextr_rodada", 32'(rodada), 32'(r + 1));
        check("nextr_pontos", 32'(pontos), 32'(100 + 5 * (r + 1)));
      end
    end
    check("win_state", 32'(db_estado), 32'(S_WIN));
    check("win_pontos", 32'(pontos), 32'd120);
    check("win_pontos_sat", 32'(pontos2), 32'd35);
    check("win_pronto", 32'(pronto), 32'd1);
    check("win_acertou", 32'(acertou), 32'd1);
    check("win_errou", 32'(errou), 32'd0);

    // 2 + 4: three wrong presses in normal mode; saturation on the low-score core
    start_game(1'b0, 1'b1);
    for (int e = 0; e < 3; e++) begin
      press(7'b0100000, "wrong");
      check("err_state", 32'(db_estado), 32'(S_ERR));
      tick();
      check("err_pontos", 32'(pontos), 32'(90 - 10 * e));
      check("err_pontos_sat", 32'(pontos2), (e == 0) ? 32'd5 : 32'd0);
      check("err_rodada", 32'(rodada), 32'd0);
      check("err_next", 32'(db_estado), (e < 2) ? 32'(S_PREP) : 32'(S_LOSE));
    end
    check("lose_errou", 32'(errou), 32'd1);
    check("lose_pronto", 32'(pronto), 32'd1);
    check("lose_acertou", 32'(acertou), 32'd0);

    // 3: training mode, wrong press then timeout
    start_game(1'b1, 1'b1);
    press(7'b0100000, "train_wrong");
    check("train_err", 32'(db_estado), 32'(S_ERR));
    tick();
    check("train_prep", 32'(db_estado), 32'(S_PREP));
    check("train_pontos", 32'(pontos), 32'd100);
    wait_state("train_wait", S_WAIT, 400);
    for (int k = 0; k < 19; k++) tick();
    check("to_still_wait", 32'(db_estado), 32'(S_WAIT));
    tick();
    check("to_err", 32'(db_estado), 32'(S_ERR));
    tick();
    check("to_prep", 32'(db_estado), 32'(S_PREP));
    check("to_pontos", 32'(pontos), 32'd100);
    check("to_rodada", 32'(rodada), 32'd0);
    check("to_no_lose", 32'(errou), 32'd0);

    // 6a: reset in the middle of SHOW
    tick();
    check("mid_show", 32'(db_estado), 32'(S_SHOW));
    reset = 1'b0;
    tick();
    check("mrst_state", 32'(db_estado), 32'(S_IDLE));
    check("mrst_leds", 32'(leds), 32'd0);
    check("mrst_ard", 32'(arduino_out), 32'd0);
    check("mrst_pontos", 32'(pontos), 32'd0);
    reset = 1'b1;
    tick();

    // 5: chord is wrong; held button across WAIT entry is ignored
    start_game(1'b0, 1'b1);
    press(7'b0001001, "chord");
    check("chord_err", 32'(db_estado), 32'(S_ERR));
    tick();
    check("chord_pontos", 32'(pontos), 32'd90);
    wait_state("held_gap", S_GAP, 400);
    botoes = 7'b0001000;
    wait_state("held_wait", S_WAIT, 400);
    check("held_leds", 32'(leds), 32'b0001000);
    check("held_ard", 32'(arduino_out), 32'd4);
    tick(); tick(); tick();
    check("held_no_press", 32'(db_estado), 32'(S_WAIT));
    botoes = '0;
    tick();
    check("released", 32'(db_estado), 32'(S_WAIT));
    press(7'b0001000, "repress");
    check("repress_ok", 32'(db_estado), 32'(S_NEXTR));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // 6b: half level ends after two rounds
    start_game(1'b0, 1'b0);
    play_round(0);
    tick();
    check("half_prep", 32'(db_estado), 32'(S_PREP));
    check("half_rodada", 32'(rodada), 32'd1);
    play_round(1);
    tick();
    check("half_win", 32'(db_estado), 32'(S_WIN));
    check("half_pontos", 32'(pontos), 32'd110);
    check("half_acertou", 32'(acertou), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
